pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
- Parameters (name, default, meaning):
REQ-001 WIDTH, 96, payload width in bits (default is a 64-bit PC plus a 32-bit instruction).
REQ-002 NOP_VALUE, all zeros (WIDTH bits), value driven on out_data whenever out_valid=0.
REQ-003 CNT_W, 16, bubble counter width in bits.
- Ports (name, direction, width, meaning):
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  kill all held entries (e.g. branch taken).
REQ-007 in_valid  input  1  upstream offers in_data.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 in_ready  output  1  block can accept this cycle; driven from a register.
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_data  output  WIDTH  head entry, or NOP_VALUE when out_valid=0.
REQ-012 out_ready  input  1  downstream consumes this cycle.
REQ-013 occupancy  output  2  entries held: 0, 1 or 2.
REQ-014 bubble_count  output  CNT_W  saturating count of cycles downstream was starved.

Function
REQ-015 Accept SHALL occur when in_valid=1 and in_ready=1; emit SHALL occur when out_valid=1 and out_ready=1.
REQ-016 The block SHALL implement a 3-state FSM: EMPTY (0 entries), ONE (main entry valid), FULL (main and skid entries valid).
REQ-017 EMPTY: accept -> ONE with main<=in_data; otherwise stay in EMPTY.
REQ-018 ONE: accept without emit -> FULL with skid<=in_data; accept with emit -> ONE with main<=in_data; emit only -> EMPTY; neither -> ONE.
REQ-019 FULL: in_ready=0, so no accept; emit -> ONE with main<=skid; otherwise stay in FULL.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, computed as a registered next-state value with no combinational path from out_ready.
REQ-021 out_valid SHALL be 1 in ONE and FULL; out_data SHALL be main when out_valid=1, else NOP_VALUE.
REQ-022 Latency: an entry accepted into EMPTY SHALL appear on out_data in the next cycle, a 1-cycle latency.
REQ-023 Ordering: entries SHALL be emitted strictly in acceptance order, with no loss or duplication except by flush.
REQ-024 Throughput: with in_valid=out_ready=1 continuously, the block SHALL sustain one accept and one emit per cycle.
REQ-025 occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL.
REQ-026 flush SHALL have priority over everything else: the next state is EMPTY, and both entries plus any same-cycle accept are discarded.
REQ-027 An emit in a flush cycle SHALL still count as completed; in_ready SHALL be 1 in the cycle after flush.
REQ-028 bubble_count SHALL increment by 1 in each cycle with out_ready=1 and out_valid=0, saturate at 2^CNT_W-1, be unaffected by flush, and clear only on reset.
REQ-029 Payload bits SHALL pass through unmodified; widths are fixed by WIDTH with no truncation or extension.

Reset
REQ-030 While reset=1 the block SHALL force the following values asynchronously: state=EMPTY, occupancy=0, out_valid=0, out_data=NOP_VALUE, in_ready=1, bubble_count=0, and main/skid cleared to NOP_VALUE.
REQ-031 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-032 in_valid offered while reset=1 SHALL NOT be accepted.

Verification
REQ-033 Single entry: after reset, in_valid=1 with in_data=0x...0040_8B020020 for one cycle, out_ready=1 -> next cycle out_valid=1 and out_data equals it; the following cycle out_valid=0 and out_data=NOP_VALUE.
REQ-034 Backpressure: out_ready=0, offer A then B -> occupancy 1 then 2, in_ready=0; C is held by upstream; raise out_ready -> A, B, C emitted in order, none lost.
REQ-035 Streaming: in_valid=out_ready=1 for 50 cycles with an incrementing payload -> 50 emits, consecutive values, in_ready=1 throughout.
REQ-036 Flush in FULL with a simultaneous offer of D -> next cycle occupancy=0, out_valid=0, in_ready=1, D never emitted.
REQ-037 Bubbles: CNT_W=2, out_ready=1, no input for 6 cycles -> bubble_count reads 1, 2, 3, 3, 3, 3; unchanged by a flush; 0 after reset.
REQ-038 Async reset: assert reset between clock edges while FULL -> outputs take their reset values before the next rising edge of clk.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: a main slot feeds out_data and a skid slot catches
// the one extra beat that arrives while downstream stalls, so in_ready can be registered.
module pipe_skid_reg #(
  parameter int               WIDTH     = 96,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_count
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             emit;

  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = out_valid ? main_q : NOP_VALUE;
  assign occupancy = state;

  // in_ready is written alongside the state so it always reflects "next state != FULL".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      main_q   <= NOP_VALUE;
      skid_q   <= NOP_VALUE;
      in_ready <= 1'b1;
    end else if (flush) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      in_ready <= 1'b1;
      case (state)
        EMPTY: begin
          if (accept) begin
            state  <= ONE;
            main_q <= in_data;
          end
        end
        ONE: begin
          if (accept && !emit) begin
            state    <= FULL;
            skid_q   <= in_data;
            in_ready <= 1'b0;
          end else if (accept && emit) begin
            main_q <= in_data;
          end else if (emit) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            state  <= ONE;
            main_q <= skid_q;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Starvation counter survives flush; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bubble_count <= '0;
    else if (out_ready && !out_valid && (bubble_count != {CNT_W{1'b1}}))
      bubble_count <= bubble_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: single beat, backpressure, streaming,
// flush, bubble saturation and asynchronous reset.
module tb_pipe_skid_reg;

  localparam int WIDTH = 96;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] bubble_count;

  pipe_skid_reg #(.WIDTH(WIDTH), .NOP_VALUE('0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [WIDTH-1:0] got[$];
  logic acc;

  task automatic chk(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: record handshakes seen in this cycle, then step past the edge.
  task automatic tick();
    if (out_valid && out_ready) got.push_back(out_data);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  localparam logic [WIDTH-1:0] PKT = 96'h0000_0000_0000_0040_8B02_0020;
  localparam logic [WIDTH-1:0] A = 96'hAAAA_0000_1111_2222_3333_0001;
  localparam logic [WIDTH-1:0] B = 96'hBBBB_0000_4444_5555_6666_0002;
  localparam logic [WIDTH-1:0] C = 96'hCCCC_0000_7777_8888_9999_0003;
  localparam logic [WIDTH-1:0] D = 96'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD;

  initial begin
    logic [WIDTH-1:0] exp_v;
    logic [WIDTH-1:0] stream[$];
    logic rdy_ok;
    int nxt;
    logic [CNT_W-1:0] bub_exp[6];
    bub_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    // Reset values, with an offer that must be ignored while reset is high.
    in_valid = 1'b1; in_data = D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_occ", 96'(occupancy), 96'd0);
    chk("rst_valid", 96'(out_valid), 96'd0);
    chk("rst_data", out_data, '0);
    chk("rst_ready", 96'(in_ready), 96'd1);
    chk("rst_bub", 96'(bubble_count), 96'd0);
    in_valid = 1'b0;
    reset = 1'b0;
    chk("rst_noacc", 96'(occupancy), 96'd0);

    // Single entry, one-cycle latency.
    in_valid = 1'b1; in_data = PKT; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_valid", 96'(out_valid), 96'd1);
    chk("single_data", out_data, PKT);
    tick();
    chk("single_gone_v", 96'(out_valid), 96'd0);
    chk("single_gone_d", out_data, '0);
    out_ready = 1'b0;

    // Backpressure: A and B fill both slots, C is held upstream.
    got.delete();
    in_valid = 1'b1; in_data = A;
    tick();
    chk("bp_occ1", 96'(occupancy), 96'd1);
    in_data = B;
    tick();
    chk("bp_occ2", 96'(occupancy), 96'd2);
    chk("bp_ready0", 96'(in_ready), 96'd0);
    chk("bp_head", out_data, A);
    in_data = C;
    tick();
    chk("bp_hold_occ", 96'(occupancy), 96'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (acc) in_valid = 1'b0;
    end
    chk("bp_count", 96'(got.size()), 96'd3);
    if (got.size() == 3) begin
      chk("bp_ord0", got[0], A);
      chk("bp_ord1", got[1], B);
      chk("bp_ord2", got[2], C);
    end

    // Streaming 50 beats back to back.
    do_reset();
    got.delete(); stream.delete();
    in_valid = 1'b1; out_ready = 1'b1; nxt = 0; rdy_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_data = {32'hC0DE_0000 | 32'(nxt), 32'h5A5A_5A5A, 32'(nxt)};
      if (!in_ready) rdy_ok = 1'b0;
      tick();
      if (acc) begin
        stream.push_back(in_data);
        nxt++;
      end
    end
    in_valid = 1'b0;
    tick();
    chk("stream_ready", 96'(rdy_ok), 96'd1);
    chk("stream_acc", 96'(stream.size()), 96'd50);
    chk("stream_emits", 96'(got.size()), 96'd50);
    for (int i = 0; i < 50 && i < got.size(); i++) begin
      exp_v = {32'hC0DE_0000 | 32'(i), 32'h5A5A_5A5A, 32'(i)};
      if (got[i] !== exp_v) chk($sformatf("stream_%0d", i), got[i], exp_v);
    end

    // Flush while FULL with D offered in the same cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = A; tick();
    in_data = B; tick();
    chk("fl_full", 96'(occupancy), 96'd2);
    flush = 1'b1; in_data = D;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_occ", 96'(occupancy), 96'd0);
    chk("fl_valid", 96'(out_valid), 96'd0);
    chk("fl_ready", 96'(in_ready), 96'd1);
    chk("fl_data", out_data, '0);
    got.delete();
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("fl_no_d", 96'(got.size()), 96'd0);

    // Bubble counter saturation; flush in step 2 must not disturb it.
    out_ready = 1'b0;
    do_reset();
    chk("bub_clr", 96'(bubble_count), 96'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      flush = (i == 1);
      tick();
      chk($sformatf("bub_%0d", i), 96'(bubble_count), 96'(bub_exp[i]));
    end
    flush = 1'b1; out_ready = 1'b0;
    tick();
    flush = 1'b0;
    chk("bub_flush", 96'(bubble_count), 96'd3);

    // Asynchronous reset between edges while FULL.
    in_valid = 1'b1; in_data = A; tick();
    in_data = B; tick();
    in_valid = 1'b0;
    chk("ar_full", 96'(occupancy), 96'd2);
    #2 reset = 1'b1;
    #1;
    chk("ar_occ", 96'(occupancy), 96'd0);
    chk("ar_valid", 96'(out_valid), 96'd0);
    chk("ar_data", out_data, '0);
    chk("ar_ready", 96'(in_ready), 96'd1);
    chk("ar_bub", 96'(bubble_count), 96'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
